// File: rtl/moa_operand_loader.sv
// Serial-to-parallel operand loader for the moa_6x8 multi-operand adder: packs N_OPS
// operands, holds them on the adder, captures the sum. Optional macro: MOA_LOADER_SELFCHECK_EN.
module moa_operand_loader #(
  parameter int N_OPS = 6,
  parameter int W     = 8,
  parameter int SW    = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  output logic [N_OPS*W-1:0] ops,
  input  logic [SW-1:0]      sum_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SW-1:0]      out_sum,
  output logic               sum_err
);

  // state  | meaning
  // S_LOAD | accepting operands into slot cnt
  // S_EVAL | frame complete, adder settling; sum captured at end of cycle
  // S_OUT  | result presented until out_ready
  localparam int CW = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last_op;

  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_OUT);
  assign accept    = in_valid & in_ready;
  assign last_op   = (cnt == CW'(N_OPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_LOAD;
      cnt     <= '0;
      ops     <= '0;
      out_sum <= '0;
    end else if (clr) begin
      state <= S_LOAD;
      cnt   <= '0;
      ops   <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (accept) begin
            for (int k = 0; k < N_OPS; k++) begin
              if (cnt == CW'(k)) ops[k*W +: W] <= in_data;
            end
            if (last_op) begin
              cnt   <= '0;
              state <= S_EVAL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_EVAL: begin
          out_sum <= sum_in;
          state   <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) state <= S_LOAD;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

`ifdef MOA_LOADER_SELFCHECK_EN
  logic [SW-1:0] acc;
  logic          err_q;

  // Running sum of the frame, compared against the external adder during EVAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      err_q <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) acc <= (cnt == '0) ? SW'(in_data) : acc + SW'(in_data);
      if (state == S_EVAL)                err_q <= (acc != sum_in);
      else if (state == S_OUT && out_ready) err_q <= 1'b0;
    end
  end

  assign sum_err = err_q;
`else
  assign sum_err = 1'b0;
`endif

endmodule

// File: tb/tb_moa_operand_loader.sv
// Self-checking bench for moa_operand_loader with a behavioural adder model on sum_in.
module tb_moa_operand_loader;
  localparam int N_OPS = 6;
  localparam int W     = 8;
  localparam int SW    = 11;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clr = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [W-1:0]       in_data = '0;
  logic [N_OPS*W-1:0] ops;
  logic [SW-1:0]      sum_in;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [SW-1:0]      out_sum;
  logic               sum_err;
  logic [SW-1:0]      sum_bias = '0;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [SW-1:0] exp_sum_q[$];
  logic          exp_err_q[$];

  moa_operand_loader #(.N_OPS(N_OPS), .W(W), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ops(ops), .sum_in(sum_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .sum_err(sum_err)
  );

  always #5 clk = ~clk;

  // External adder model, with an optional fault bias
  always_comb begin
    logic [SW-1:0] s;
    s = '0;
    for (int k = 0; k < N_OPS; k++) s = s + SW'(ops[k*W +: W]);
    sum_in = s + sum_bias;
  end

  task automatic send_op(input logic [W-1:0] d, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (!in_ready) $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
    else pass_cnt++;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] d[N_OPS], input int gap);
    logic [SW-1:0] s;
    logic          e;
    s = '0;
    for (int k = 0; k < N_OPS; k++) s = s + SW'(d[k]);
`ifdef MOA_LOADER_SELFCHECK_EN
    e = (sum_bias != '0);
`else
    e = 1'b0;
`endif
    exp_sum_q.push_back(s + sum_bias);
    exp_err_q.push_back(e);
    for (int k = 0; k < N_OPS; k++) send_op(d[k], gap);
  endtask

  task automatic recv(input int hold);
    int n;
    logic [SW-1:0] es;
    logic          ee;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    es = exp_sum_q.pop_front();
    ee = exp_err_q.pop_front();
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL out_valid_timeout: out_valid=%0b required 1", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_sum !== es) $display("FAIL out_sum: got 0x%0h required 0x%0h", out_sum, es);
    else pass_cnt++;
    total_cnt++;
    if (sum_err !== ee) $display("FAIL sum_err: got %0b required %0b", sum_err, ee);
    else pass_cnt++;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b1 || out_sum !== es || sum_err !== ee || in_ready !== 1'b0)
        $display("FAIL hold: out_valid=%0b out_sum=0x%0h sum_err=%0b in_ready=%0b required 1/0x%0h/%0b/0",
                 out_valid, out_sum, sum_err, in_ready, es, ee);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum_err !== 1'b0)
      $display("FAIL after_handshake: out_valid=%0b in_ready=%0b sum_err=%0b required 0/1/0",
               out_valid, in_ready, sum_err);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || ops !== '0 || out_sum !== '0 || sum_err !== 1'b0)
      $display("FAIL reset: in_ready=%0b out_valid=%0b ops=0x%0h out_sum=0x%0h sum_err=%0b required 1/0/0/0/0",
               in_ready, out_valid, ops, out_sum, sum_err);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_max_frame();
    logic [W-1:0] d[N_OPS];
    for (int k = 0; k < N_OPS; k++) d[k] = 8'hFF;
    send_frame(d, 0);
    // now one edge after the last handshake: EVAL
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL latency_eval: out_valid=%0b in_ready=%0b required 0/0", out_valid, in_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL latency_out: out_valid=%0b required 1", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_sum !== 11'h5FA) $display("FAIL max_sum: got 0x%0h required 0x5fa", out_sum);
    else pass_cnt++;
    recv(0);
  endtask

  task automatic test_gaps();
    logic [W-1:0] d[N_OPS];
    for (int k = 0; k < N_OPS; k++) d[k] = W'(k + 1);
    send_frame(d, 2);
    total_cnt++;
    if (ops !== 48'h060504030201) $display("FAIL ops_pack: got 0x%0h required 0x060504030201", ops);
    else pass_cnt++;
    recv(0);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d[N_OPS];
    for (int k = 0; k < N_OPS; k++) d[k] = W'(8'h20 + k * 3);
    send_frame(d, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL busy_in_ready: in_ready=%0b required 0", in_ready);
    else pass_cnt++;
    recv(5);
    in_valid = 1'b0;
    for (int k = 0; k < N_OPS; k++) d[k] = W'(k * 7 + 1);
    send_frame(d, 0);
    recv(0);
  endtask

  task automatic test_clr();
    logic [W-1:0] d[N_OPS];
    send_op(8'hAA, 0);
    send_op(8'hBB, 0);
    send_op(8'hCC, 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total_cnt++;
    if (ops !== '0 || in_ready !== 1'b1) $display("FAIL clr_partial: ops=0x%0h in_ready=%0b required 0/1", ops, in_ready);
    else pass_cnt++;
    for (int k = 0; k < N_OPS; k++) d[k] = 8'h10;
    send_frame(d, 0);
    total_cnt++;
    if (ops !== 48'h101010101010) $display("FAIL clr_repack: ops=0x%0h required 0x101010101010", ops);
    else pass_cnt++;
    recv(0);
    // clear while a result is pending, with out_ready also high
    for (int k = 0; k < N_OPS; k++) d[k] = 8'h01;
    send_frame(d, 0);
    void'(exp_sum_q.pop_front());
    void'(exp_err_q.pop_front());
    @(negedge clk);
    clr       = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    clr       = 1'b0;
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || ops !== '0 || in_ready !== 1'b1)
      $display("FAIL clr_out: out_valid=%0b ops=0x%0h in_ready=%0b required 0/0/1", out_valid, ops, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [W-1:0] d[N_OPS];
    for (int k = 0; k < N_OPS; k++) d[k] = 8'h33;
    send_frame(d, 0);
    void'(exp_sum_q.pop_front());
    void'(exp_err_q.pop_front());
    #1;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || ops !== '0 || in_ready !== 1'b1)
      $display("FAIL async_reset: out_valid=%0b ops=0x%0h in_ready=%0b required 0/0/1", out_valid, ops, in_ready);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N_OPS; k++) d[k] = W'(8'h40 + k);
    send_frame(d, 1);
    recv(0);
  endtask

  task automatic test_selfcheck();
    logic [W-1:0] d[N_OPS];
    for (int k = 0; k < N_OPS; k++) d[k] = W'(k * 11 + 5);
    sum_bias = 11'd1;
    send_frame(d, 0);
    recv(0);
    sum_bias = 11'd0;
    send_frame(d, 0);
    recv(0);
  endtask

  initial begin
    test_reset();
    test_max_frame();
    test_gaps();
    test_backpressure();
    test_clr();
    test_async_reset();
    test_selfcheck();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time=%0t required completion", $time);
    $fatal(1, "timeout");
  end
endmodule
